// File: rtl/sram_pkg.sv
// Shared types and default widths for the SRAM access controller.
// The SRAM_BYTE_MASK_EN macro adds a byte-mask field to the request record.
package sram_pkg;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_DLY_W  = 8;

  typedef enum logic [1:0] {IDLE, DELAY, ISSUE} state_t;

  // Request record at default widths; the top builds the same layout from its parameters.
  typedef struct packed {
`ifdef SRAM_BYTE_MASK_EN
    logic [DEF_DATA_W/8-1:0] wmask;
`endif
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   wdata;
    logic                    we;
    logic [DEF_DLY_W-1:0]    delay;
  } req_t;
endpackage

// File: rtl/sram_sync_fifo.sv
// Single-clock FIFO with full/empty flags; DEPTH must be a power of two.
module sram_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr <= wptr + ONE;
      end
      if (do_pop) rptr <= rptr + ONE;
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];
endmodule

// File: rtl/sram_access_ctrl.sv
// Request scheduler for a single-port synchronous SRAM: queue, per-request delay, credit-protected read return.
// Define SRAM_BYTE_MASK_EN to add per-write byte masks (req_wmask / sram_wmask).
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DLY_W     = DEF_DLY_W,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  input  logic [DLY_W-1:0]  req_delay,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic [DATA_W/8-1:0] sram_wmask,
`endif
  output logic              sram_cs,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);
  localparam int MASK_W = DATA_W/8;
  localparam int CR_W   = $clog2(RSP_DEPTH+1);

  typedef struct packed {
`ifdef SRAM_BYTE_MASK_EN
    logic [MASK_W-1:0] wmask;
`endif
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DLY_W-1:0]  delay;
  } ent_t;

  ent_t req_in, req_head;
  logic req_full, req_empty, req_push, req_pop, rdy_q;
  state_t state;
  logic [DLY_W-1:0]  dly_cnt;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
`ifdef SRAM_BYTE_MASK_EN
  logic [MASK_W-1:0] cur_mask;
`endif
  logic [CR_W-1:0]   credits;
  logic [RD_LAT:0]   vld_pipe;
  logic can_issue, chain, issue_rd, rsp_full, rsp_empty, rsp_pop;

  always_comb begin
    req_in       = '0;
    req_in.addr  = req_addr;
    req_in.wdata = req_wdata;
    req_in.we    = req_we;
    req_in.delay = req_delay;
`ifdef SRAM_BYTE_MASK_EN
    req_in.wmask = req_wmask;
`endif
  end

  // rdy_q keeps req_ready low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end

  assign req_ready = rdy_q && !req_full;
  assign req_push  = req_valid && req_ready;
  assign can_issue = (state == ISSUE) && (cur_we || credits != '0);
  assign chain     = can_issue && !req_empty && (req_head.delay == '0);
  assign req_pop   = ((state == IDLE) && !req_empty) || chain;
  assign issue_rd  = can_issue && !cur_we;

  sram_sync_fifo #(.WIDTH($bits(ent_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk(clk), .rstn(rstn), .push(req_push), .din(req_in), .pop(req_pop),
    .dout(req_head), .full(req_full), .empty(req_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      sram_cs   <= 1'b0;
      sram_wen  <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
`ifdef SRAM_BYTE_MASK_EN
      cur_mask   <= '0;
      sram_wmask <= '0;
`endif
    end else begin
      sram_cs  <= 1'b0;
      sram_wen <= 1'b0;
      if (req_pop) begin
        cur_we    <= req_head.we;
        cur_addr  <= req_head.addr;
        cur_wdata <= req_head.wdata;
`ifdef SRAM_BYTE_MASK_EN
        cur_mask  <= req_head.wmask;
`endif
      end
      unique case (state)
        IDLE: if (!req_empty) begin
          dly_cnt <= req_head.delay;
          state   <= (req_head.delay != '0) ? DELAY : ISSUE;
        end
        DELAY: begin
          if (dly_cnt == DLY_W'(1)) state <= ISSUE;
          else dly_cnt <= dly_cnt - DLY_W'(1);
        end
        ISSUE: if (can_issue) begin
          sram_cs   <= 1'b1;
          sram_wen  <= cur_we;
          sram_addr <= cur_addr;
          sram_din  <= cur_wdata;
`ifdef SRAM_BYTE_MASK_EN
          sram_wmask <= cur_we ? cur_mask : '1;
`endif
          if (!chain) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // vld_pipe[0] coincides with the read's sram_cs cycle; data is captured as the tag leaves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[RD_LAT-1:0], issue_rd};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) credits <= CR_W'(RSP_DEPTH);
    else       credits <= credits + CR_W'(rsp_pop) - CR_W'(issue_rd);
  end

  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  sram_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk), .rstn(rstn), .push(vld_pipe[RD_LAT]), .din(sram_rdata), .pop(rsp_pop),
    .dout(rsp_rdata), .full(rsp_full), .empty(rsp_empty)
  );

  // Credits reserve a slot per read issued, so a capture can never meet a full FIFO.
  rsp_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(vld_pipe[RD_LAT] && rsp_full));

  assign busy = !req_empty || (state != IDLE) || (|vld_pipe) || rsp_valid;
endmodule
